// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM encoding, round count, bit-mixing functions
// and the standard IV / round constants used to drive the core in benches.
package sha256_pkg;

    localparam int ROUNDS = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [2047:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: maps working variables a..h
// (a in the top word) to their next values given Wt and Kt.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression core: one round per clock over a 16-word
// sliding message schedule, chaining H across the blocks of a message.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          block_valid,
    output logic          block_ready,
    input  logic [511:0]  block_data,
    input  logic          block_first,
    input  logic          block_last,
    input  logic [255:0]  initialHashValues,
    input  logic [2047:0] constantValues,
    output logic [255:0]  digest,
    output logic          digest_valid
);

    state_t        state_reg, state_next;
    logic [5:0]    cnt_reg;
    logic [31:0]   w_reg [16];
    logic [255:0]  base_reg;
    logic [255:0]  vars_reg;
    logic [255:0]  vars_next;
    logic [255:0]  h_reg;
    logic [255:0]  h_sum;
    logic [255:0]  chain_base;
    logic          last_reg;
    logic          accept;
    logic [31:0]   k_t;
    logic [31:0]   w_new;

    assign accept     = block_valid && block_ready;
    assign chain_base = block_first ? initialHashValues : h_reg;

    // K0 sits in the top word, so word index 63-cnt is simply ~cnt.
    assign k_t   = constantValues[{~cnt_reg, 5'd0} +: 32];
    assign w_new = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];

    sha256_round u_round (
        .state_in  (vars_reg),
        .w         (w_reg[0]),
        .k         (k_t),
        .state_out (vars_next)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
            assign h_sum[gi*32 +: 32] = base_reg[gi*32 +: 32] + vars_reg[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_ROUND;
            ST_ROUND:  if (cnt_reg == 6'(ROUNDS - 1)) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        block_ready = (state_reg == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            base_reg     <= '0;
            vars_reg     <= '0;
            h_reg        <= '0;
            last_reg     <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w_reg[i] <= '0;
            end
        end else begin
            digest_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < 16; i++) begin
                            w_reg[i] <= block_data[511 - 32*i -: 32];
                        end
                        last_reg <= block_last;
                        base_reg <= chain_base;
                        vars_reg <= chain_base;
                        cnt_reg  <= '0;
                    end
                end
                ST_ROUND: begin
                    vars_reg <= vars_next;
                    for (int i = 0; i < 15; i++) begin
                        w_reg[i] <= w_reg[i+1];
                    end
                    w_reg[15] <= w_new;
                    cnt_reg   <= cnt_reg + 6'd1;
                end
                ST_UPDATE: begin
                    h_reg <= h_sum;
                    if (last_reg) begin
                        digest       <= h_sum;
                        digest_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: known-answer vectors, protocol corner cases and
// a randomized stream checked every cycle against a cycle-count/hash model.
module tb_sha256_compress;
    import sha256_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          block_valid = 1'b0;
    logic          block_ready;
    logic [511:0]  block_data = '0;
    logic          block_first = 1'b0;
    logic          block_last = 1'b0;
    logic [255:0]  initialHashValues = SHA256_IV;
    logic [2047:0] constantValues = SHA256_K;
    logic [255:0]  digest;
    logic          digest_valid;

    sha256_compress dut (
        .clk               (clk),
        .rst               (rst),
        .block_valid       (block_valid),
        .block_ready       (block_ready),
        .block_data        (block_data),
        .block_first       (block_first),
        .block_last        (block_last),
        .initialHashValues (initialHashValues),
        .constantValues    (constantValues),
        .digest            (digest),
        .digest_valid      (digest_valid)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {480'd0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain FIPS 180-4 compression with a full 64-entry schedule.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]   wv [64];
        logic [31:0]   v [8];
        logic [31:0]   t1, t2, s0, s1;
        logic [2047:0] kk;
        logic [255:0]  res;
        kk = SHA256_K;
        for (int t = 0; t < 16; t++) wv[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3);
            s1 = rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10);
            wv[t] = s1 + wv[t-7] + s0 + wv[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk[2047 - 32*t -: 32] + wv[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // Reference: busy for 65 edges after an accepted block, then publishes.
    int           m_busy = 0;
    logic [255:0] m_h = '0;
    logic [255:0] m_digest = '0;
    logic [255:0] m_pend = '0;
    logic         m_last = 1'b0;
    logic         m_dv = 1'b0;
    logic         m_init = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_dv = 1'b0;
        if (rst) begin
            m_busy = 0;
            m_h = '0;
            m_digest = '0;
        end else if (m_busy == 0) begin
            if (block_valid) begin
                m_pend = model_compress(block_first ? initialHashValues : m_h, block_data);
                m_last = block_last;
                m_busy = 65;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                m_h = m_pend;
                if (m_last) begin
                    m_digest = m_pend;
                    m_dv = 1'b1;
                end
            end
        end
        m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("block_ready", 256'(block_ready), 256'(m_busy == 0));
            chk("digest_valid", 256'(digest_valid), 256'(m_dv));
            chk("digest", digest, m_digest);
        end
    end

    task automatic send(input logic [511:0] d, input logic f, input logic l);
        int n;
        @(negedge clk);
        block_data = d; block_first = f; block_last = l; block_valid = 1'b1;
        n = 0;
        while (!block_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!block_ready) chk("send_timeout", 256'(block_ready), 256'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        block_valid = 1'b0;
    endtask

    task automatic wait_digest(input string name, input logic [255:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!digest_valid && n < 300);
        chk({name, "_seen"}, 256'(digest_valid), 256'd1);
        chk({name, "_latency"}, 256'(cyc - acc_cyc), 256'd65);
        chk(name, digest, exp);
    endtask

    logic [511:0] rd;

    initial begin
        // Pin the model itself to the published vectors.
        chk("model_abc", model_compress(SHA256_IV, ABC_BLK), ABC_DIG);
        chk("model_two", model_compress(model_compress(SHA256_IV, TWO_B1), TWO_B2), TWO_DIG);

        repeat (3) @(negedge clk);
        chk("reset_digest", digest, 256'd0);
        chk("reset_dv", 256'(digest_valid), 256'd0);
        chk("reset_ready", 256'(block_ready), 256'd1);
        rst = 1'b0;

        send(ABC_BLK, 1'b1, 1'b1);
        wait_digest("abc", ABC_DIG);

        send(TWO_B1, 1'b1, 1'b0);
        send(TWO_B2, 1'b0, 1'b1);
        wait_digest("two_block", TWO_DIG);

        // A competing block held during ROUND must be ignored.
        send(ABC_BLK, 1'b1, 1'b1);
        block_data = {16{32'hdeadbeef}}; block_first = 1'b1; block_last = 1'b1; block_valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("busy_ready", 256'(block_ready), 256'd0);
        end
        block_valid = 1'b0;
        wait_digest("abc_ignore", ABC_DIG);

        // Reset in the middle of ROUND discards the block.
        send(ABC_BLK, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_digest", digest, 256'd0);
        chk("midreset_dv", 256'(digest_valid), 256'd0);
        chk("midreset_ready", 256'(block_ready), 256'd1);
        repeat (80) @(negedge clk);
        send(ABC_BLK, 1'b1, 1'b1);
        wait_digest("abc_after_reset", ABC_DIG);

        // Back-to-back accept in the digest_valid cycle.
        block_data = ABC_BLK; block_first = 1'b1; block_last = 1'b1; block_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        block_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_digest", digest, ABC_DIG);
        wait_digest("abc_b2b", ABC_DIG);

        // Randomized stream, including rare resets and unchained first blocks.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) rd[i*32 +: 32] = $urandom();
            block_data  = rd;
            block_valid = ($urandom_range(0, 3) == 0);
            block_first = ($urandom_range(0, 2) == 0);
            block_last  = ($urandom_range(0, 2) != 0);
            rst         = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        block_valid = 1'b0;
        rst = 1'b0;
        repeat (70) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
